// File: rtl/argmax_fp32.sv
// argmax_fp32: sequential argmax over NUM_CLASS FP32 scores, one compare per cycle.
// NaNs never win against numbers; ties keep the lowest index.
module argmax_fp32 #(
  parameter int NUM_CLASS = 7,
  parameter int IDX_W     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  output logic                   ready_in,
  input  logic [NUM_CLASS*32-1:0] class_flat,
  output logic                   valid_out,
  input  logic                   ready_out,
  output logic [IDX_W-1:0]       max_idx,
  output logic [31:0]            max_val,
  output logic                   nan_seen
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] mem_q [NUM_CLASS];
  logic [IDX_W-1:0] cnt_q, cnt_d, idx_q, idx_d;
  logic [31:0] val_q, val_d, cur;
  logic nan_q, nan_d, accept, scan, last, repl;
  function automatic logic is_nan(input logic [31:0] x);
    return (&x[30:23]) && (|x[22:0]);
  endfunction
  // Monotonic unsigned key; both zeros collapse onto the +0 key.
  function automatic logic [31:0] key(input logic [31:0] x);
    return ~|x[30:0] ? 32'h8000_0000 : x[31] ? ~x : {1'b1, x[30:0]};
  endfunction
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q == IDLE ? (valid_in ? (NUM_CLASS == 1 ? DONE : SCAN) : IDLE)
            : state_q == SCAN ? (last ? DONE : SCAN)
            : (ready_out ? IDLE : DONE);
  end
  always_comb begin
    ready_in  = state_q == IDLE;
    valid_out = state_q == DONE;
  end
  always_comb begin
    accept = state_q == IDLE && valid_in;
    scan   = state_q == SCAN;
    last   = cnt_q == IDX_W'(NUM_CLASS - 1);
    cur    = mem_q[cnt_q];
    repl   = !is_nan(cur) && (is_nan(val_q) || key(cur) > key(val_q));
    idx_d  = accept ? '0 : (scan && repl) ? cnt_q : idx_q;
    val_d  = accept ? class_flat[31:0] : (scan && repl) ? cur : val_q;
    nan_d  = accept ? is_nan(class_flat[31:0]) : scan ? (nan_q | is_nan(cur)) : nan_q;
    cnt_d  = accept ? IDX_W'(1) : scan ? cnt_q + IDX_W'(1) : cnt_q;
  end
  always_ff @(posedge clk)
    if (accept)
      for (int i = 0; i < NUM_CLASS; i++) mem_q[i] <= class_flat[32*i +: 32];
  always_ff @(posedge clk)
    if (rst) begin
      idx_q <= '0;
      val_q <= '0;
      nan_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      val_q <= val_d;
      nan_q <= nan_d;
      cnt_q <= cnt_d;
    end
  assign max_idx  = idx_q;
  assign max_val  = val_q;
  assign nan_seen = nan_q;
endmodule

// File: tb/tb_argmax_fp32.sv
// tb_argmax_fp32: table, random and corner-sequence checks of argmax_fp32 (7, 1 and 16 classes).
module tb_argmax_fp32;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, valid_in, ready_in, valid_out, ready_out, nan_seen;
  logic [6:0][31:0] class_flat;
  logic [2:0] max_idx;
  logic [31:0] max_val;
  logic v1_in, r1_in, v1_out, r1_out, n1;
  logic [31:0] f1, mv1;
  logic [0:0] i1;
  logic v16_in, r16_in, v16_out, r16_out, n16;
  logic [15:0][31:0] f16;
  logic [3:0] i16;
  logic [31:0] mv16;
  argmax_fp32 #(.NUM_CLASS(7), .IDX_W(3)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in), .class_flat(class_flat),
    .valid_out(valid_out), .ready_out(ready_out), .max_idx(max_idx), .max_val(max_val), .nan_seen(nan_seen));
  argmax_fp32 #(.NUM_CLASS(1), .IDX_W(1)) dut1 (
    .clk(clk), .rst(rst), .valid_in(v1_in), .ready_in(r1_in), .class_flat(f1),
    .valid_out(v1_out), .ready_out(r1_out), .max_idx(i1), .max_val(mv1), .nan_seen(n1));
  argmax_fp32 #(.NUM_CLASS(16), .IDX_W(4)) dut16 (
    .clk(clk), .rst(rst), .valid_in(v16_in), .ready_in(r16_in), .class_flat(f16),
    .valid_out(v16_out), .ready_out(r16_out), .max_idx(i16), .max_val(mv16), .nan_seen(n16));
  int n_chk = 0, n_err = 0;
  typedef struct {
    logic [6:0][31:0] v;
    logic [2:0] idx;
    logic [31:0] val;
    logic nan;
    string name;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  function automatic logic nan_f(input logic [31:0] x);
    return x[30:23] == 8'hff && x[22:0] != 0;
  endfunction
  // Reference: numeric value as signed magnitude; first non-NaN maximum wins.
  function automatic void model(input logic [15:0][31:0] v, input int n, output int idx,
                                output logic [31:0] val, output logic nan);
    int s, best;
    idx = -1; nan = 1'b0; best = 0;
    for (int i = 0; i < n; i++) begin
      if (nan_f(v[i])) nan = 1'b1;
      else begin
        s = v[i][31] ? -int'({1'b0, v[i][30:0]}) : int'({1'b0, v[i][30:0]});
        if (idx < 0 || s > best) begin idx = i; best = s; end
      end
    end
    if (idx < 0) idx = 0;
    val = v[idx];
  endfunction
  function automatic logic [31:0] rnd_elem();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return {r[31], 8'hff, r[22:0] | 23'h1};
      1: return {r[31], 31'h0};
      2: return {r[31], 8'hff, 23'h0};
      3: return r[0] ? 32'h3f800000 : 32'hbf800000;
      default: return r;
    endcase
  endfunction
  task automatic send(input logic [6:0][31:0] v, output int lat);
    @(negedge clk);
    class_flat = v;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    class_flat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    lat = 1;
    while (!valid_out && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic check_res(input string nm, input int lat, input logic [31:0] idx,
                           input logic [31:0] val, input logic nan);
    chk({nm, " latency"}, lat, 7);
    chk({nm, " max_idx"}, {29'h0, max_idx}, idx);
    chk({nm, " max_val"}, max_val, val);
    chk({nm, " nan_seen"}, {31'h0, nan_seen}, {31'h0, nan});
  endtask
  task automatic release_res(input string nm);
    ready_out = 1'b1;
    @(negedge clk);
    ready_out = 1'b0;
    chk({nm, " ready_in after release"}, {31'h0, ready_in}, 1);
    chk({nm, " valid_out after release"}, {31'h0, valid_out}, 0);
  endtask
  initial begin
    int lat, midx, seen;
    logic [31:0] mval, hold_val;
    logic [2:0] hold_idx;
    logic mnan;
    logic [6:0][31:0] v;
    tbl[0] = '{{32'h44db3e56, 32'hc41c84af, 32'hc4c98fd5, 32'h4458bf69, 32'h43fe437b,
                32'hc593a346, 32'hc4204551}, 3'd6, 32'h44db3e56, 1'b0, "nominal"};
    tbl[1] = '{{{3{32'h80000000}}, 32'h00000000, {3{32'h80000000}}}, 3'd0, 32'h80000000, 1'b0, "signed_zero"};
    tbl[2] = '{{32'hbf800000, 32'h3f800000, {2{32'hbf800000}}, 32'h3f800000, {2{32'hbf800000}}},
               3'd2, 32'h3f800000, 1'b0, "tie"};
    tbl[3] = '{{{2{32'hff7fffff}}, 32'hff800000, {3{32'hff7fffff}}, 32'h7fc00000},
               3'd1, 32'hff7fffff, 1'b1, "nan_first"};
    tbl[4] = '{{7{32'h7fc00000}}, 3'd0, 32'h7fc00000, 1'b1, "all_nan"};
    tbl[5] = '{{32'h0, 32'h7f800001, 32'h0, 32'h7f800000, {3{32'h0}}}, 3'd3, 32'h7f800000, 1'b1, "inf_vs_nan"};
    rst = 1'b1; valid_in = 1'b0; ready_out = 1'b0; class_flat = '0;
    v1_in = 1'b0; r1_out = 1'b0; f1 = '0; v16_in = 1'b0; r16_out = 1'b0; f16 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset ready_in", {31'h0, ready_in}, 1);
    chk("reset valid_out", {31'h0, valid_out}, 0);
    chk("reset max_idx", {29'h0, max_idx}, 0);
    chk("reset max_val", max_val, 0);
    chk("reset nan_seen", {31'h0, nan_seen}, 0);
    for (int k = 0; k < 6; k++) begin
      send(tbl[k].v, lat);
      check_res(tbl[k].name, lat, {29'h0, tbl[k].idx}, tbl[k].val, tbl[k].nan);
      release_res(tbl[k].name);
    end
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 7; i++) v[i] = rnd_elem();
      model(v, 7, midx, mval, mnan);
      send(v, lat);
      check_res("random", lat, midx, mval, mnan);
      release_res("random");
    end
    send(tbl[0].v, lat);
    check_res("bp", lat, 6, 32'h44db3e56, 1'b0);
    hold_idx = max_idx; hold_val = max_val;
    class_flat = tbl[1].v;
    valid_in = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp hold flags", {29'h0, valid_out, ready_in, nan_seen}, 32'h4);
      chk("bp hold idx", {29'h0, max_idx}, {29'h0, hold_idx});
      chk("bp hold val", max_val, hold_val);
    end
    valid_in = 1'b0;
    release_res("bp");
    send(tbl[2].v, lat);
    check_res("bp next", lat, 2, 32'h3f800000, 1'b0);
    release_res("bp next");
    @(negedge clk);
    class_flat = tbl[4].v;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midscan ready_in", {31'h0, ready_in}, 1);
    chk("midscan valid_out", {31'h0, valid_out}, 0);
    chk("midscan max_idx", {29'h0, max_idx}, 0);
    chk("midscan max_val", max_val, 0);
    chk("midscan nan_seen", {31'h0, nan_seen}, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (valid_out) seen++;
    end
    chk("midscan no valid_out", seen, 0);
    send(tbl[3].v, lat);
    check_res("prio", lat, 1, 32'hff7fffff, 1'b1);
    rst = 1'b1; ready_out = 1'b1; valid_in = 1'b1; class_flat = tbl[0].v;
    @(negedge clk);
    rst = 1'b0; ready_out = 1'b0; valid_in = 1'b0;
    chk("prio ready_in", {31'h0, ready_in}, 1);
    chk("prio valid_out", {31'h0, valid_out}, 0);
    chk("prio max_val", max_val, 0);
    chk("prio nan_seen", {31'h0, nan_seen}, 0);
    @(negedge clk);
    chk("prio stays idle", {31'h0, ready_in}, 1);
    @(negedge clk);
    f1 = $urandom;
    mval = f1;
    v1_in = 1'b1;
    @(negedge clk);
    v1_in = 1'b0;
    f1 = ~f1;
    lat = 1;
    while (!v1_out && lat < 40) begin @(negedge clk); lat++; end
    chk("n1 latency", lat, 1);
    chk("n1 max_idx", {31'h0, i1}, 0);
    chk("n1 max_val", mv1, mval);
    r1_out = 1'b1;
    @(negedge clk);
    r1_out = 1'b0;
    chk("n1 ready_in", {31'h0, r1_in}, 1);
    for (int i = 0; i < 15; i++) f16[i] = $urandom & 32'hbfffffff;
    f16[15] = 32'h7f800000;
    model(f16, 16, midx, mval, mnan);
    chk("n16 model idx", midx, 15);
    v16_in = 1'b1;
    @(negedge clk);
    v16_in = 1'b0;
    f16 = '0;
    lat = 1;
    while (!v16_out && lat < 60) begin @(negedge clk); lat++; end
    chk("n16 latency", lat, 16);
    chk("n16 max_idx", {28'h0, i16}, midx);
    chk("n16 max_val", mv16, mval);
    chk("n16 nan_seen", {31'h0, n16}, {31'h0, mnan});
    r16_out = 1'b1;
    @(negedge clk);
    r16_out = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/argmax_fp32.md
ARGMAX_FP32 -- requirements
Module: argmax_fp32

Interface
REQ-001 SHALL have parameter NUM_CLASS, default 7, number of FP32 class scores per vector (legal range 1..256).
REQ-002 SHALL have parameter IDX_W, default 3, index width, equal to max(1, clog2(NUM_CLASS)).
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port valid_in, input, 1, score vector present on class_flat.
REQ-006 SHALL have port ready_in, output, 1, block can accept a vector.
REQ-007 SHALL have port class_flat, input, NUM_CLASS*32, IEEE-754 single scores; class i at bits [32*i+31:32*i].
REQ-008 SHALL have port valid_out, output, 1, result valid.
REQ-009 SHALL have port ready_out, input, 1, downstream accepts result.
REQ-010 SHALL have port max_idx, output, IDX_W, index of the winning class.
REQ-011 SHALL have port max_val, output, 32, FP32 bit pattern of the winning score.
REQ-012 SHALL have port nan_seen, output, 1, at least one input was NaN.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, DONE.
- ready_in = 1 only in IDLE.
- valid_out = 1 only in DONE.
REQ-014 SHALL accept a vector on a rising edge with valid_in=1 and ready_in=1.
- On that edge: capture class_flat into an internal register and load element 0 as the candidate.
- Go to SCAN, or to DONE if NUM_CLASS=1.
REQ-015 SHALL compare one element per cycle in SCAN, indices 1..NUM_CLASS-1 in ascending order.
- Leave SCAN for DONE on the edge that processes index NUM_CLASS-1.
REQ-016 SHALL make valid_out rise exactly NUM_CLASS cycles after the accept edge (7 cycles for the default).
REQ-017 SHALL hold max_idx, max_val and nan_seen stable in DONE until an edge with ready_out=1, then go to IDLE.
- Back-to-back throughput: one vector per NUM_CLASS+1 cycles with ready_out held at 1.
REQ-018 SHALL order values using key(x):
- sign=0 -> {1'b1, x[30:0]}.
- sign=1 -> ~x.
- Both +0 and -0 map to the same key as +0.
- Infinities order naturally.
REQ-019 SHALL replace the candidate only when key(element) > key(candidate), so the lowest index wins ties.
REQ-020 SHALL treat NaN (exponent 0xFF, mantissa nonzero) as follows:
- A NaN element never replaces a non-NaN candidate and sets nan_seen.
- A NaN candidate is replaced by the first non-NaN element.
- All-NaN vector -> max_idx=0, max_val=element 0 bits.
REQ-021 SHALL ignore class_flat and valid_in outside IDLE; the captured copy is used so input changes mid-scan have no effect.
REQ-022 SHALL clear nan_seen at each accept.

Reset
REQ-023 SHALL, on an edge with rst=1, enter IDLE and drive valid_out=0, ready_in=1 from the next cycle, max_idx=0, max_val=32'h0 and nan_seen=0.
REQ-024 SHALL abort any scan in progress or result awaiting ready_out when rst=1 mid-operation, with no valid_out pulse for the aborted vector.
REQ-025 SHALL give rst priority over simultaneous valid_in and ready_out.

Verification
REQ-026 SHALL cover a nominal default vector:
- Inputs, class0..6: c4204551, c593a346, 43fe437b, 4458bf69, c4c98fd5, c41c84af, 44db3e56.
- Required: valid_out 7 cycles after accept, max_idx=6, max_val=44db3e56, nan_seen=0.
REQ-027 SHALL cover ties and signed zero:
- Vector all 80000000 except class3=00000000 -> max_idx=0, max_val=80000000.
- Vector class2=class5=3f800000, others bf800000 -> max_idx=2.
REQ-028 SHALL cover NaN handling:
- class0=7fc00000, class4=ff800000, others ff7fffff -> max_idx=1, max_val=ff7fffff, nan_seen=1.
- All 7fc00000 -> max_idx=0, nan_seen=1.
REQ-029 SHALL cover backpressure:
- Hold ready_out=0 for 10 cycles after valid_out.
- Required: outputs stable, ready_in=0, a new valid_in is ignored.
- Then ready_out=1 for one cycle -> IDLE, next vector accepted.
REQ-030 SHALL cover reset mid-scan:
- Assert rst for 1 cycle 3 cycles after accept.
- Required: no valid_out, ready_in=1 next cycle, all outputs at reset values.
REQ-031 SHALL cover parameter sweep:
- NUM_CLASS=1 -> valid_out 1 cycle after accept, max_idx=0.
- NUM_CLASS=16 with max at class15 = 7f800000 -> max_idx=15, latency 16.
